// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: holds the fetch PC, issues in-order imem requests,
// buffers responses for decode and flushes on execute redirects.
//
// Ports:
//   clk_i, rst_ni             clock, async active-low reset
//   redirect_valid_i/pc_i     1-cycle redirect pulse and target
//   imem_req_valid_o/ready_i  request handshake, imem_req_addr_o
//   imem_rsp_valid_i/data_i   in-order response, err_i = access fault
//   if_valid_o/if_ready_i     decode handshake, if_pc_o/instr_o/err_o
module fetch_pc_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  input  logic            imem_rsp_err_i,
  output logic            if_valid_o,
  input  logic            if_ready_i,
  output logic [XLEN-1:0] if_pc_o,
  output logic [31:0]     if_instr_o,
  output logic            if_err_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            err;
  } ent_t;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   occ_q, occ_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            mwait_q, mwait_d;
  logic            blk_q, blk_d;

  logic [XLEN-1:0] pq_q [DEPTH];
  ent_t            rf_q [DEPTH];
  logic [PW-1:0]   pq_rd_q, pq_wr_q;
  logic [PW-1:0]   rf_rd_q, rf_wr_q;
  logic [CW-1:0]   pq_cnt_q, rf_cnt_q;

  logic            req_hs, dec_hs, err_acc;
  logic            rf_empty;
  logic            flush, pq_push, pq_pop;
  logic            rf_push, mis_push, discard;
  ent_t            rf_head, rf_wdata;
  logic [XLEN-1:0] pq_head;
  logic [CW-1:0]   inflight;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    if (32'(p) == DEPTH - 1) return '0;
    return p + PW'(1);
  endfunction

  assign rf_head  = rf_q[rf_rd_q];
  assign pq_head  = pq_q[pq_rd_q];
  assign rf_empty = (rf_cnt_q == '0);

  // A redirect kills the presented entry in the same cycle.
  assign if_valid_o = !rf_empty && !redirect_valid_i;
  assign if_pc_o    = rf_empty ? '0 : rf_head.pc;
  assign if_instr_o = rf_empty ? '0 : rf_head.instr;
  assign if_err_o   = rf_empty ? '0 : rf_head.err;

  assign dec_hs  = if_valid_o && if_ready_i;
  assign err_acc = dec_hs && rf_head.err;

  // A slot freed by decode this cycle can be reused at once,
  // which keeps DEPTH=2 gap-free with 1-cycle memory.
  assign imem_req_valid_o = (state_q == S_FETCH) && !blk_q &&
                            ((occ_q < DEPTH_C) || dec_hs);
  assign imem_req_addr_o  = {pc_q[XLEN-1:2], 2'b00};
  assign req_hs = imem_req_valid_o && imem_req_ready_i;

  // Requests still owed a response once this cycle settles.
  assign inflight = occ_q - rf_cnt_q + CW'(req_hs)
                  - CW'(imem_rsp_valid_i);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    occ_d    = occ_q;
    drop_d   = drop_q;
    mwait_d  = mwait_q;
    blk_d    = blk_q;
    flush    = 1'b0;
    pq_push  = 1'b0;
    pq_pop   = 1'b0;
    rf_push  = 1'b0;
    mis_push = 1'b0;
    discard  = 1'b0;
    rf_wdata = '0;
    unique case (1'b1)
      redirect_valid_i: begin
        flush   = 1'b1;
        drop_d  = inflight;
        occ_d   = inflight;
        pc_d    = redirect_pc_i;
        state_d = S_FETCH;
        mwait_d = |redirect_pc_i[1:0];
        blk_d   = |redirect_pc_i[1:0];
      end
      err_acc: begin
        flush   = 1'b1;
        drop_d  = inflight;
        occ_d   = inflight;
        state_d = S_HALT;
        mwait_d = 1'b0;
        blk_d   = 1'b0;
      end
      default: begin
        if (state_q == S_BOOT) state_d = S_FETCH;
        if (req_hs) begin
          pq_push = 1'b1;
          pc_d    = pc_q + XLEN'(4);
        end
        if (imem_rsp_valid_i) begin
          if (drop_q != '0) begin
            discard = 1'b1;
            drop_d  = drop_q - CW'(1);
          end else begin
            pq_pop         = 1'b1;
            rf_push        = 1'b1;
            rf_wdata.pc    = pq_head;
            rf_wdata.err   = imem_rsp_err_i;
            rf_wdata.instr = imem_rsp_err_i ? '0
                                            : imem_rsp_data_i;
          end
        end
        // Misaligned target: fault entry once stale fetches drain.
        if (mwait_q && drop_q == '0) begin
          mis_push       = 1'b1;
          rf_push        = 1'b1;
          rf_wdata.pc    = pc_q;
          rf_wdata.instr = '0;
          rf_wdata.err   = 1'b1;
          mwait_d        = 1'b0;
        end
        occ_d = occ_q + CW'(req_hs) + CW'(mis_push)
              - CW'(dec_hs) - CW'(discard);
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      occ_q    <= '0;
      drop_q   <= '0;
      mwait_q  <= 1'b0;
      blk_q    <= 1'b0;
      pq_rd_q  <= '0;
      pq_wr_q  <= '0;
      pq_cnt_q <= '0;
      rf_rd_q  <= '0;
      rf_wr_q  <= '0;
      rf_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      occ_q   <= occ_d;
      drop_q  <= drop_d;
      mwait_q <= mwait_d;
      blk_q   <= blk_d;
      if (flush) begin
        pq_rd_q  <= '0;
        pq_wr_q  <= '0;
        pq_cnt_q <= '0;
        rf_rd_q  <= '0;
        rf_wr_q  <= '0;
        rf_cnt_q <= '0;
      end else begin
        if (pq_push) pq_wr_q <= inc(pq_wr_q);
        if (pq_pop)  pq_rd_q <= inc(pq_rd_q);
        if (rf_push) rf_wr_q <= inc(rf_wr_q);
        if (dec_hs)  rf_rd_q <= inc(rf_rd_q);
        pq_cnt_q <= pq_cnt_q + CW'(pq_push) - CW'(pq_pop);
        rf_cnt_q <= rf_cnt_q + CW'(rf_push) - CW'(dec_hs);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (pq_push) pq_q[pq_wr_q] <= pc_q;
    if (rf_push) rf_q[rf_wr_q] <= rf_wdata;
  end

  a_rsp_owned: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    imem_rsp_valid_i |-> (pq_cnt_q != '0 || drop_q != '0));

  a_occ_bound: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    occ_q <= DEPTH_C);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed scenarios plus a randomized run of
// fetch_pc_unit against a stream-level model of the fetch order.
module tb_fetch_pc_unit;

  localparam int DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        imem_rsp_err_i = 1'b0;
  logic        if_valid_o;
  logic        if_ready_i = 1'b0;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_err_o;

  fetch_pc_unit #(
    .XLEN(32), .RESET_PC(32'h0), .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_valid_o(imem_req_valid_o),
    .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o),
    .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i(imem_rsp_data_i),
    .imem_rsp_err_i(imem_rsp_err_i),
    .if_valid_o(if_valid_o),
    .if_ready_i(if_ready_i),
    .if_pc_o(if_pc_o),
    .if_instr_o(if_instr_o),
    .if_err_o(if_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // memory: outstanding request addresses, answered in order
  logic [31:0] mq[$];
  logic [31:0] err_addr = 32'h1;
  int rdy_pct = 100, dec_pct = 100, rsp_pct = 100;

  // fetch-order model
  logic [31:0] m_next_req, m_next_dec;
  logic        m_halt, m_mis;
  logic        p_vld, p_rdy, p_kill;
  logic [31:0] p_addr;
  int n_req, n_dec, n_dec_all;
  logic [31:0] first_dec_pc;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hA5C3_0F69;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_next_req = 32'h0;
    m_next_dec = 32'h0;
    m_halt = 1'b0;
    m_mis  = 1'b0;
    p_vld  = 1'b0;
    p_rdy  = 1'b0;
    p_kill = 1'b0;
    p_addr = '0;
  endtask

  task automatic do_reset();
    #2 rst_ni = 1'b0;
    redirect_valid_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid_o), 0);
    chk("rst_req_addr", imem_req_addr_o, 0);
    chk("rst_if_valid", 32'(if_valid_o), 0);
    chk("rst_if_pc", if_pc_o, 0);
    chk("rst_if_instr", if_instr_o, 0);
    chk("rst_if_err", 32'(if_err_o), 0);
    model_clear();
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic step(input logic redir, input logic [31:0] tgt);
    logic rh, dh, rv, e;
    redirect_valid_i = redir;
    redirect_pc_i    = redir ? tgt : $urandom;
    imem_req_ready_i = ($urandom_range(99) < rdy_pct);
    if_ready_i       = ($urandom_range(99) < dec_pct);
    rv = (mq.size() > 0) && ($urandom_range(99) < rsp_pct);
    imem_rsp_valid_i = rv;
    if (rv) begin
      imem_rsp_data_i = mdata(mq[0]);
      imem_rsp_err_i  = (mq[0] == err_addr);
    end else begin
      imem_rsp_data_i = $urandom;
      imem_rsp_err_i  = $urandom_range(1);
    end
    @(negedge clk_i);
    rh = imem_req_valid_o && imem_req_ready_i;
    dh = if_valid_o && if_ready_i && !redir;
    if (redir) chk("redirect_kill", 32'(if_valid_o), 0);
    if (m_halt || m_mis)
      chk("no_req_when_stopped", 32'(imem_req_valid_o), 0);
    if (m_halt) chk("no_valid_when_halted", 32'(if_valid_o), 0);
    if (p_vld && !p_rdy && !p_kill) begin
      chk("req_valid_hold", 32'(imem_req_valid_o), 1);
      chk("req_addr_hold", imem_req_addr_o, p_addr);
    end
    if (rh) begin
      chk("req_addr", imem_req_addr_o, m_next_req);
      m_next_req += 32'd4;
      n_req++;
    end
    e = 1'b0;
    if (dh) begin
      if (n_dec == 0) first_dec_pc = if_pc_o;
      e = m_mis || (m_next_dec == err_addr);
      chk("dec_pc", if_pc_o, m_next_dec);
      chk("dec_err", 32'(if_err_o), 32'(e));
      chk("dec_instr", if_instr_o, e ? 32'h0 : mdata(m_next_dec));
      if (e) begin
        m_halt = 1'b1;
        m_mis  = 1'b0;
      end
      m_next_dec += 32'd4;
      n_dec++;
      n_dec_all++;
    end
    if (rv) void'(mq.pop_front());
    if (rh) mq.push_back(imem_req_addr_o);
    chk("outstanding_bound", 32'(mq.size() <= DEPTH), 1);
    p_vld  = imem_req_valid_o;
    p_rdy  = imem_req_ready_i;
    p_addr = imem_req_addr_o;
    p_kill = redir || (dh && e);
    if (redir) begin
      m_next_req = tgt;
      m_next_dec = tgt;
      m_halt = 1'b0;
      m_mis  = (tgt[1:0] != 2'b00);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  initial begin
    int r0;
    logic [31:0] t;
    n_dec_all = 0;
    model_clear();

    // 1: back-to-back fetch from reset, no bubbles
    do_reset();
    n_req = 0; n_dec = 0;
    step(1'b0, 0);
    chk("t1_boot_no_req", 32'(n_req), 0);
    run(9);
    chk("t1_req_count", 32'(n_req), 9);
    chk("t1_dec_count", 32'(n_dec), 7);
    chk("t1_first_pc", first_dec_pc, 32'h0);

    // 2: decode stalled, DEPTH requests then stop
    do_reset();
    dec_pct = 0;
    n_req = 0; n_dec = 0;
    run(7);
    chk("t2_req_count", 32'(n_req), 2);
    chk("t2_req_valid_low", 32'(imem_req_valid_o), 0);
    dec_pct = 100;
    step(1'b0, 0);
    chk("t2_release_req", 32'(n_req), 3);
    chk("t2_release_dec", 32'(n_dec), 1);

    // 3: redirect with two fetches in flight
    do_reset();
    rsp_pct = 0;
    n_req = 0; n_dec = 0;
    run(5);
    chk("t3_inflight", 32'(n_req), 2);
    step(1'b1, 32'h100);
    run(3);
    chk("t3_wait_drain", 32'(n_req), 2);
    rsp_pct = 100;
    run(10);
    chk("t3_progress", 32'(n_dec > 0), 1);
    chk("t3_first_pc", first_dec_pc, 32'h100);

    // 4: redirect together with rsp and request handshake
    do_reset();
    n_req = 0; n_dec = 0;
    run(2);
    step(1'b1, 32'h200);
    chk("t4_req_in_redirect", 32'(n_req), 2);
    step(1'b0, 0);
    chk("t4_new_req_next", 32'(n_req), 3);
    run(8);
    chk("t4_first_pc", first_dec_pc, 32'h200);

    // 5: memory fault at 0x8 halts fetch
    do_reset();
    err_addr = 32'h8;
    n_req = 0; n_dec = 0;
    run(15);
    chk("t5_dec_count", 32'(n_dec), 3);
    chk("t5_halted", 32'(m_halt), 1);
    step(1'b1, 32'h200);
    n_dec = 0;
    run(10);
    chk("t5_resumed", 32'(n_dec > 3), 1);

    // 6: misaligned redirect, then async reset mid-stream
    step(1'b1, 32'h102);
    n_req = 0; n_dec = 0;
    run(10);
    chk("t6_one_err_entry", 32'(n_dec), 1);
    chk("t6_no_req", 32'(n_req), 0);
    chk("t6_halted", 32'(m_halt), 1);
    step(1'b1, 32'h300);
    run(4);
    do_reset();
    err_addr = 32'h1;
    n_req = 0; n_dec = 0;
    run(3);
    chk("t6_restart_reqs", 32'(n_req), 2);

    // randomized traffic and redirects
    rdy_pct = 70; dec_pct = 70; rsp_pct = 60;
    r0 = n_dec_all;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(m_halt ? 4 : 39) == 0) begin
        t = $urandom & 32'h0000_0FFC;
        if ($urandom_range(7) == 0) t = t | 32'h2;
        if ($urandom_range(15) == 0) t = 32'hFFFF_FFF4;
        if ($urandom_range(3) == 0)
          err_addr = t + 32'(4 * $urandom_range(5));
        else
          err_addr = 32'h1;
        step(1'b1, t);
      end else begin
        step(1'b0, 0);
      end
    end
    chk("rand_progress", 32'(n_dec_all - r0 > 200), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
